uart_tx_arbiter: RTL and testbench

- Shares one txuart transmitter among NREQ independent byte-stream requesters (status reporter, debug console, message generators).
- Grants are packet-locked: a requester keeps the transmitter until it presents a byte flagged last.
- Selection among waiting requesters is round-robin.
- Sits between requesters and txuart, and drives txuart's stb/data handshake.

---
 rtl/uart_arb_pkg.sv | 10 +
 rtl/uart_rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 92 +++++++++
 tb/tb_uart_tx_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM encoding and default sizing for the txuart arbiter.
package uart_arb_pkg;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_XFER = 1'b1;
    localparam int DEF_TIMEOUT = 50000;
    localparam int DEF_TWIDTH = 16;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker, searching ptr+1, ptr+2, ... modulo N.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  win_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    logic found;
    int k;
    always_comb begin
        win_o = '0;
        idx_o = '0;
        found = 1'b0;
        k = 0;
        for (int o = 1; o <= N; o++) begin
            k = (int'(ptr_i) + o) % N;
            if (!found && req_i[k]) begin
                found = 1'b1;
                win_o[k] = 1'b1;
                idx_o = IW'(k);
            end
        end
    end
    assign any_o = |req_i;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin sharing of one txuart among NREQ byte streams.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TWIDTH = DEF_TWIDTH
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [NREQ-1:0]   i_req,
    input  logic [8*NREQ-1:0] i_data,
    input  logic [NREQ-1:0]   i_last,
    output logic [NREQ-1:0]   o_ack,
    output logic [NREQ-1:0]   o_grant,
    output logic              o_timeout,
    output logic              o_tx_stb,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_busy
);
    localparam int IW = idx_w(NREQ);
    logic [0:0] state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [TWIDTH-1:0] cnt_q, cnt_d;
    logic stb_q, stb_d, tout_q, tout_d;
    logic [7:0] data_q, data_d;
    logic [NREQ-1:0] pick_win;
    logic [IW-1:0] pick_idx;
    logic pick_any, req_g, free, load, expire;

    uart_rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req_i(i_req),
        .ptr_i(ptr_q),
        .win_o(pick_win),
        .idx_o(pick_idx),
        .any_o(pick_any)
    );

    // While in XFER the pointer is the granted index.
    assign req_g = i_req[ptr_q];
    assign free = !stb_q || !i_tx_busy;
    assign load = state_q == S_XFER && req_g && free;
    assign expire = state_q == S_XFER && !req_g && cnt_q == TWIDTH'(TIMEOUT - 1);
    assign o_ack = load ? grant_q : '0;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d = ptr_q;
        cnt_d = load ? '0 : cnt_q + TWIDTH'(!req_g);
        tout_d = expire;
        stb_d = load || (stb_q && !free);
        data_d = load ? i_data[{ptr_q, 3'b000} +: 8] : data_q;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
            if (pick_any) begin
                state_d = S_XFER;
                grant_d = pick_win;
                ptr_d = pick_idx;
            end
        end else if ((load && i_last[ptr_q]) || expire) begin
            state_d = S_IDLE;
            grant_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q <= IW'(NREQ - 1);
            cnt_q <= '0;
            stb_q <= 1'b0;
            tout_q <= 1'b0;
            data_q <= 8'h00;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            stb_q <= stb_d;
            tout_q <= tout_d;
            data_q <= data_d;
        end
    end

    assign o_grant = grant_q;
    assign o_timeout = tout_q;
    assign o_tx_stb = stb_q;
    assign o_tx_data = data_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: picker vector table, directed packet sequences and a randomized
// scoreboard run for the txuart arbiter.
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic i_reset_n, i_tx_busy, o_timeout, o_tx_stb;
    logic [N-1:0] i_req, i_last, o_ack, o_grant;
    logic [8*N-1:0] i_data;
    logic [7:0] o_tx_data;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(N), .TIMEOUT(TO), .TWIDTH(16)) dut (
        .i_clk(clk), .i_reset_n(i_reset_n), .i_req(i_req), .i_data(i_data),
        .i_last(i_last), .o_ack(o_ack), .o_grant(o_grant), .o_timeout(o_timeout),
        .o_tx_stb(o_tx_stb), .o_tx_data(o_tx_data), .i_tx_busy(i_tx_busy)
    );

    logic [3:0] pk_req, pk_win;
    logic [1:0] pk_ptr, pk_idx;
    logic pk_any;
    uart_rr_pick #(.N(4), .IW(2)) u_pick (
        .req_i(pk_req), .ptr_i(pk_ptr), .win_o(pk_win), .idx_o(pk_idx), .any_o(pk_any)
    );

    typedef struct {
        logic [3:0] req;
        logic [1:0] ptr;
        logic [3:0] win;
        logic [1:0] idx;
        logic any;
    } pick_vec_t;
    pick_vec_t vec [10];

    int checks = 0, errors = 0, cyc = 0;
    logic [7:0] qd [N][$];
    logic ql [N][$];
    logic [7:0] pend [$];
    bit pres [N];
    int busy_len = 0, busy_cnt = 0, owner = -1, last_owner = N - 1;
    bit gate = 1'b0, acc_now = 1'b0, prev_stb = 1'b0;
    logic [N-1:0] prev_req = '0, prev_grant = '0;
    int acc_d[$], acc_c[$], ack_c[$], grant_c[$], grant_k[$], gfall_c[$], tout_c[$], stbr_c[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic int first1(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit quiet();
        for (int k = 0; k < N; k++) if (qd[k].size() != 0) return 1'b0;
        return pend.size() == 0 && o_grant == '0 && !o_tx_stb;
    endfunction

    task automatic clr_logs();
        acc_d.delete(); acc_c.delete(); ack_c.delete(); grant_c.delete();
        grant_k.delete(); gfall_c.delete(); tout_c.delete(); stbr_c.delete();
    endtask

    task automatic pkt(input int k, input string s, input bit lst);
        for (int i = 0; i < s.len(); i++) begin
            qd[k].push_back(s[i]);
            ql[k].push_back(lst && i == s.len() - 1);
        end
    endtask

    // Sampled at the falling edge; all inputs were settled since the rising edge.
    task automatic observe();
        int k, g, e;
        acc_now = o_tx_stb && !i_tx_busy;
        if (acc_now) begin
            acc_d.push_back(int'(o_tx_data));
            acc_c.push_back(cyc);
            if (pend.size() == 0) chk("accept_unexpected", 1, 0);
            else chk("accept_byte", int'(o_tx_data), int'(pend.pop_front()));
        end
        if (o_ack != '0) begin
            k = first1(o_ack);
            ack_c.push_back(cyc);
            chk("ack_onehot", $countones(o_ack), 1);
            chk("ack_granted", int'(o_ack & ~o_grant), 0);
            if (owner >= 0) chk("interleave", k, owner);
            if (qd[k].size() == 0) chk("ack_without_req", 1, 0);
            else begin
                pend.push_back(qd[k].pop_front());
                owner = ql[k].pop_front() ? -1 : k;
            end
            pres[k] = 1'b0;
        end
        if (o_grant != '0 && prev_grant == '0) begin
            g = first1(o_grant);
            e = -1;
            for (int o = 1; o <= N; o++)
                if (e < 0 && prev_req[(last_owner + o) % N]) e = (last_owner + o) % N;
            grant_c.push_back(cyc);
            grant_k.push_back(g);
            chk("grant_onehot", $countones(o_grant), 1);
            chk("rr_order", g, e);
            last_owner = g;
        end
        if (o_grant == '0 && prev_grant != '0) gfall_c.push_back(cyc);
        if (o_timeout) begin
            tout_c.push_back(cyc);
            owner = -1;
        end
        if (o_tx_stb && !prev_stb) stbr_c.push_back(cyc);
        prev_req = i_req;
        prev_grant = o_grant;
        prev_stb = o_tx_stb;
    endtask

    task automatic drive();
        busy_cnt = acc_now ? (busy_len < 0 ? int'($urandom_range(0, 3)) : busy_len)
                           : (busy_cnt > 0 ? busy_cnt - 1 : 0);
        i_tx_busy = busy_cnt > 0;
        for (int k = 0; k < N; k++) begin
            if (!pres[k] && qd[k].size() != 0 && (!gate || owner == k || $urandom_range(0, 1) == 1))
                pres[k] = 1'b1;
            i_req[k] = pres[k];
            i_data[8*k +: 8] = pres[k] ? qd[k][0] : 8'h00;
            i_last[k] = pres[k] ? ql[k][0] : 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        cyc++;
        @(negedge clk);
        observe();
    endtask

    task automatic run_until(input int maxc);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!quiet() && n < maxc);
        chk("run_bound", int'(quiet()), 1);
    endtask

    // Resets DUT and the bench's requester/txuart models together.
    task automatic do_reset();
        @(posedge clk);
        #1;
        i_reset_n = 1'b0;
        i_req = '0;
        i_data = '0;
        i_last = '0;
        i_tx_busy = 1'b0;
        for (int k = 0; k < N; k++) begin
            qd[k].delete();
            ql[k].delete();
            pres[k] = 1'b0;
        end
        pend.delete();
        owner = -1;
        last_owner = N - 1;
        busy_cnt = 0;
        acc_now = 1'b0;
        @(posedge clk);
        #1;
        i_reset_n = 1'b1;
        cyc++;
        prev_req = '0;
        prev_grant = '0;
        prev_stb = 1'b0;
        @(negedge clk);
        observe();
        clr_logs();
    endtask

    initial begin
        string s;
        int c0, total, len;
        i_reset_n = 1'b0;
        i_req = '0;
        i_data = '0;
        i_last = '0;
        i_tx_busy = 1'b0;
        vec[0] = '{4'b0000, 2'd0, 4'b0000, 2'd0, 1'b0};
        vec[1] = '{4'b0001, 2'd3, 4'b0001, 2'd0, 1'b1};
        vec[2] = '{4'b0101, 2'd0, 4'b0100, 2'd2, 1'b1};
        vec[3] = '{4'b0101, 2'd2, 4'b0001, 2'd0, 1'b1};
        vec[4] = '{4'b1111, 2'd3, 4'b0001, 2'd0, 1'b1};
        vec[5] = '{4'b1111, 2'd1, 4'b0100, 2'd2, 1'b1};
        vec[6] = '{4'b1000, 2'd3, 4'b1000, 2'd3, 1'b1};
        vec[7] = '{4'b0010, 2'd1, 4'b0010, 2'd1, 1'b1};
        vec[8] = '{4'b1010, 2'd0, 4'b0010, 2'd1, 1'b1};
        vec[9] = '{4'b1010, 2'd1, 4'b1000, 2'd3, 1'b1};
        for (int i = 0; i < 10; i++) begin
            pk_req = vec[i].req;
            pk_ptr = vec[i].ptr;
            #1;
            chk($sformatf("pick_win[%0d]", i), int'(pk_win), int'(vec[i].win));
            chk($sformatf("pick_any[%0d]", i), int'(pk_any), int'(vec[i].any));
            if (vec[i].any) chk($sformatf("pick_idx[%0d]", i), int'(pk_idx), int'(vec[i].idx));
        end

        do_reset();
        chk("rst_stb", int'(o_tx_stb), 0);
        chk("rst_data", int'(o_tx_data), 0);
        chk("rst_grant", int'(o_grant), 0);
        chk("rst_timeout", int'(o_timeout), 0);

        // Latency with an idle transmitter.
        pkt(0, "U", 1'b1);
        c0 = cyc + 1;
        run_until(100);
        chk("lat_grant", at(grant_c, 0), c0 + 1);
        chk("lat_ack", at(ack_c, 0), c0 + 1);
        chk("lat_stb", at(stbr_c, 0), c0 + 2);

        // "Hi\r\n" with a slow transmitter.
        do_reset();
        busy_len = 10;
        pkt(0, "Hi\r\n", 1'b1);
        run_until(400);
        s = "Hi\r\n";
        chk("hi_count", acc_d.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("hi_byte[%0d]", i), at(acc_d, i), int'(s[i]));
        chk("hi_grant_drop", at(gfall_c, 0), at(ack_c, 3) + 1);
        chk("hi_no_timeout", tout_c.size(), 0);

        // Two simultaneous packets, then requester 0 comes back at once.
        do_reset();
        busy_len = 2;
        pkt(0, "AAA", 1'b1);
        pkt(0, "B", 1'b1);
        pkt(2, "CCC", 1'b1);
        run_until(400);
        s = "AAACCCB";
        chk("two_count", acc_d.size(), 7);
        for (int i = 0; i < 7; i++) chk($sformatf("two_byte[%0d]", i), at(acc_d, i), int'(s[i]));

        // Four requesters, continuous single-byte packets.
        do_reset();
        busy_len = 0;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < N; k++) pkt(k, (k == 0) ? "a" : (k == 1) ? "b" : (k == 2) ? "c" : "d", 1'b1);
        run_until(400);
        chk("rr_grants", grant_k.size(), 12);
        for (int i = 0; i < 12; i++) chk($sformatf("rr_owner[%0d]", i), at(grant_k, i), i % N);

        // Revocation of an abandoned grant.
        do_reset();
        pkt(1, "X", 1'b0);
        pkt(3, "Y", 1'b1);
        run_until(400);
        chk("to_pulses", tout_c.size(), 1);
        chk("to_when", at(tout_c, 0), at(ack_c, 0) + TO + 1);
        chk("to_regrant_when", at(grant_c, 1), at(tout_c, 0) + 1);
        chk("to_regrant_who", at(grant_k, 1), 3);
        chk("to_bytes", at(acc_d, 1), int'("Y"));

        // Back-to-back bytes with the transmitter never busy.
        do_reset();
        pkt(2, "01234567", 1'b1);
        run_until(200);
        s = "01234567";
        chk("b2b_count", acc_d.size(), 8);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("b2b_gap[%0d]", i), at(acc_c, i) - at(acc_c, i - 1), 1);
            chk($sformatf("b2b_byte[%0d]", i), at(acc_d, i), int'(s[i]));
        end

        // Reset while a byte is on the strobe.
        do_reset();
        busy_len = 3;
        pkt(0, "0123", 1'b1);
        for (int i = 0; i < 20 && !o_tx_stb; i++) step();
        step();
        chk("pre_rst_stb", int'(o_tx_stb), 1);
        do_reset();
        chk("mid_rst_stb", int'(o_tx_stb), 0);
        chk("mid_rst_grant", int'(o_grant), 0);
        pkt(2, "Z", 1'b1);
        pkt(0, "Q", 1'b1);
        run_until(200);
        chk("post_rst_first", at(grant_k, 0), 0);

        // Randomized traffic against the scoreboard.
        do_reset();
        gate = 1'b1;
        busy_len = -1;
        total = 0;
        for (int p = 0; p < 60; p++) begin
            c0 = int'($urandom_range(0, N - 1));
            len = int'($urandom_range(1, 4));
            for (int b = 0; b < len; b++) begin
                qd[c0].push_back(8'($urandom));
                ql[c0].push_back(b == len - 1);
            end
            total += len;
        end
        run_until(5000);
        chk("rand_count", acc_d.size(), total);
        chk("rand_no_timeout", tout_c.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
